comparator_vec_checker: RTL and testbench
=========================================

// Module: comparator_vec_checker
// PURPOSE
// - Sequential stimulus driver and response checker for the 1-bit two-input comparator
//   (a, b -> out); the hardware counterpart of the comparator's bench.
// - Drives a/b vectors into the comparator, samples its out, and checks each sample
//   against a built-in reference function.
// - Counts mismatches and reports pass/fail, so comparator instances can self-test
//   on the FPGA without a simulator.
// PARAMETERS
// - NUM_VECTORS  16       vectors per run (>=4); vectors 0..3 are exhaustive, the rest come from the LFSR
// - LAT          0        comparator latency in clocks (0 = combinational)
// - MODE         0        reference function: 0 out=(a==b), 1 out=(a>b), 2 out=(a<b)
// - LFSR_SEED    8'hA5    LFSR reset/start value; must be nonzero
// PORTS
// - clk          in   1   single clock, rising edge
// - rst          in   1   synchronous, active-high reset
// - start        in   1   begin a run; sampled only in IDLE
// - dut_a        out  1   comparator input a (registered)
// - dut_b        out  1   comparator input b (registered)
// - dut_out      in   1   comparator result
// - busy         out  1   high while a run is in progress
// - done         out  1   one-cycle pulse when a run completes
// - pass         out  1   result of the last completed run (err_count==0)
// - err_count    out  8   mismatches in the current/last run; saturates at 255
// - first_err    out  8   index of the first mismatching vector; 8'hFF if none
// BEHAVIOUR
// - Reset (rst=1 at an edge): state=IDLE; dut_a=dut_b=busy=done=pass=0; err_count=0;
//   first_err=8'hFF; LFSR=LFSR_SEED.
//   - Reset mid-run aborts the run immediately, with the same values. No done pulse.
// - FSM states: IDLE -> DRIVE -> DONE -> IDLE.
//   - IDLE with start=1 at edge k: go to DRIVE; busy=1; vector 0 on dut_a/dut_b;
//     err_count=0; first_err=8'hFF; LFSR=LFSR_SEED; pass keeps its old value.
//   - DRIVE: vector i is held from edge k+i*(LAT+1) for LAT+1 cycles.
//     - dut_out is sampled at edge k+(i+1)*(LAT+1). At that same edge vector i+1 is
//       driven, or the FSM goes to DONE after the last vector.
//   - DONE (one cycle): done=1; busy=0; dut_a=dut_b=0; pass=(final err_count==0).
//     Then IDLE. Entry to DONE is at edge k+NUM_VECTORS*(LAT+1).
//   - start while busy or in DONE is ignored. Holding start high re-runs from IDLE.
// - Vector generation:
//   - i=0..3: {dut_a,dut_b} = i[1:0], giving 00, 01, 10, 11.
//   - i>=4: {dut_a,dut_b} = LFSR[1:0].
//   - The LFSR advances once per vector from i=4 on, the step being taken as the vector
//     is loaded. Polynomial x^8+x^6+x^5+x^4+1: q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}.
// - Check at each sample edge: expected = MODE function of the vector held.
//   - On mismatch: err_count += 1, saturating at 255.
//   - On the first mismatch only: first_err = i[7:0].
//   - MODE values other than 0..2 behave as MODE 0.
// - Vector index counter is wide enough for NUM_VECTORS-1. The hold counter counts
//   0..LAT and wraps.
// TESTING
// - Comparator modelled as out=(a==b), LAT=0, MODE=0, start pulsed at edge k:
//   - 16 cycles of vectors, then done=1 at edge k+16.
//   - pass=1, err_count=0, first_err=8'hFF.
// - Model forced out=~(a==b), NUM_VECTORS=4:
//   - err_count=4, first_err=0, pass=0.
//   - done asserts at edge k+4.
// - LAT=2 with a registered 2-stage comparator model:
//   - each vector held 3 cycles; done at edge k+48; pass=1.
//   - Repeat with LAT=1 against the same model: err_count>0.
// - MODE=1 with an a>b model, first 4 vectors:
//   - expected out sequence 0,0,1,0; no errors.
//   - Model forced stuck-at-1: first_err=0, err_count counts all vectors with a<=b.
// - Reset mid-run: assert rst at edge k+5.
//   - Next cycle: busy=0, done never pulses, dut_a=dut_b=0, err_count=0.
//   - A following start reproduces the identical vector sequence (same seed).
// - start re-pulsed while busy:
//   - no restart, done at the original edge.
//   - NUM_VECTORS=300 with a faulty model: err_count saturates at 255.

Source files
------------

// File: rtl/comparator_vec_checker.sv
// comparator_vec_checker: drives exhaustive + LFSR vectors into a 1-bit comparator and counts mismatches
module comparator_vec_checker #(
  parameter int NUM_VECTORS = 16,
  parameter int LAT = 0,
  parameter int MODE = 0,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_err
);
  localparam int IW = $clog2(NUM_VECTORS);
  localparam int HW = LAT > 0 ? $clog2(LAT + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] idx;
  logic [IW:0] idx_n;
  logic [HW-1:0] hold;
  logic [7:0] lfsr, lfsr_n, err_n;
  logic expected, sample, mismatch, last, lo4;
  logic [1:0] vec_n;
  always_comb begin
    expected = MODE == 1 ? dut_a & ~dut_b : MODE == 2 ? ~dut_a & dut_b : dut_a ~^ dut_b;
    sample   = state == DRIVE && hold == HW'(LAT);
    mismatch = sample && dut_out != expected;
    last     = idx == IW'(NUM_VECTORS - 1);
    err_n    = err_count + 8'(mismatch && err_count != 8'hFF);
    lfsr_n   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    idx_n    = {1'b0, idx} + (IW+1)'(1);
    lo4      = idx_n[IW:2] == '0;
    vec_n    = lo4 ? idx_n[1:0] : lfsr_n[1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {dut_a, dut_b, busy, done, pass} <= '0;
      err_count <= '0;
      first_err <= 8'hFF;
      lfsr <= LFSR_SEED;
      idx <= '0;
      hold <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        state <= DRIVE;
        busy <= 1'b1;
        {dut_a, dut_b} <= 2'b00;
        idx <= '0;
        hold <= '0;
        err_count <= '0;
        first_err <= 8'hFF;
        lfsr <= LFSR_SEED;
      end else if (state == DRIVE) begin
        hold <= sample ? '0 : hold + HW'(1);
        if (sample) begin
          err_count <= err_n;
          if (mismatch && err_count == 8'd0) first_err <= 8'(idx);
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
            {dut_a, dut_b} <= 2'b00;
            pass <= err_n == 8'd0;
          end else begin
            idx <= idx_n[IW-1:0];
            {dut_a, dut_b} <= vec_n;
            if (!lo4) lfsr <= lfsr_n;
          end
        end
      end else if (state == DONE) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_comparator_vec_checker.sv
// tb_comparator_vec_checker: several checker configurations against comparator models, checked against a reference
module tb_comparator_vec_checker;
  localparam int NI = 6;
  localparam int NVS   [NI] = '{16, 4, 16, 16, 4, 300};
  localparam int LATS  [NI] = '{0, 0, 2, 1, 0, 0};
  localparam int MODES [NI] = '{0, 0, 0, 0, 1, 0};
  logic clk = 0, rst = 1;
  logic start [NI], dut_a [NI], dut_b [NI], dut_out [NI], busy [NI], done [NI], pass [NI];
  logic [7:0] errc [NI], first [NI];
  int fm [NI];
  int checks = 0, errors = 0;
  logic [2:0] seq [$];
  logic [2:0] saved [$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : gi
    logic ideal, base;
    logic [1:0] pipe;
    assign ideal = MODES[g] == 1 ? dut_a[g] & ~dut_b[g] : MODES[g] == 2 ? ~dut_a[g] & dut_b[g] : dut_a[g] ~^ dut_b[g];
    always_ff @(posedge clk) pipe <= {pipe[0], ideal};
    assign base = LATS[g] > 0 ? pipe[1] : ideal;
    assign dut_out[g] = fm[g] == 1 ? ~base : fm[g] == 2 ? 1'b1 : base;
    comparator_vec_checker #(.NUM_VECTORS(NVS[g]), .LAT(LATS[g]), .MODE(MODES[g]), .LFSR_SEED(8'hA5)) u (
      .clk(clk), .rst(rst), .start(start[g]), .dut_a(dut_a[g]), .dut_b(dut_b[g]), .dut_out(dut_out[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .err_count(errc[g]), .first_err(first[g]));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int vec_at(input int i);
    logic [7:0] q = 8'hA5;
    if (i < 4) return i;
    for (int j = 4; j <= i; j++) q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    return int'(q[1:0]);
  endfunction
  function automatic void exp_run(input int nv, input int mode, input int fmode, output int err, output int fe);
    err = 0;
    fe = 255;
    for (int i = 0; i < nv; i++) begin
      int v, a, b;
      bit r, mo;
      v = vec_at(i);
      a = v / 2;
      b = v % 2;
      r = mode == 1 ? a > b : mode == 2 ? a < b : a == b;
      mo = fmode == 1 ? !r : fmode == 2 ? 1'b1 : r;
      if (mo != r) begin
        if (err == 0) fe = i;
        if (err < 255) err++;
      end
    end
  endfunction
  task automatic run(input int g, input int repulse, output int cyc);
    seq.delete();
    @(negedge clk) start[g] = 1;
    @(posedge clk) #1 start[g] = 0;
    chk("busy_on", 32'(busy[g]), 1);
    seq.push_back({dut_out[g], dut_a[g], dut_b[g]});
    cyc = 0;
    while (!done[g] && cyc < 5000) begin
      @(negedge clk) start[g] = (cyc == repulse);
      @(posedge clk) #1;
      cyc++;
      if (!done[g]) seq.push_back({dut_out[g], dut_a[g], dut_b[g]});
    end
    start[g] = 0;
    chk("done_seen", 32'(done[g]), 1);
    chk("busy_off", 32'(busy[g]), 0);
    chk("ab_idle", 32'({dut_a[g], dut_b[g]}), 0);
    @(posedge clk) #1;
    chk("done_pulse", 32'(done[g]), 0);
  endtask
  task automatic check_result(input int g, input int fmode);
    int e, f;
    exp_run(NVS[g], MODES[g], fmode, e, f);
    chk("err_count", 32'(errc[g]), 32'(e));
    chk("first_err", 32'(first[g]), 32'(f));
    chk("pass", 32'(pass[g]), 32'(e == 0));
  endtask
  initial begin
    int cyc, e, f;
    bit saw_done;
    for (int g = 0; g < NI; g++) begin
      start[g] = 0;
      fm[g] = 0;
    end
    fm[1] = 1;
    fm[5] = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_busy", 32'(busy[g]), 0);
      chk("rst_done", 32'(done[g]), 0);
      chk("rst_pass", 32'(pass[g]), 0);
      chk("rst_err", 32'(errc[g]), 0);
      chk("rst_first", 32'(first[g]), 32'hFF);
      chk("rst_ab", 32'({dut_a[g], dut_b[g]}), 0);
    end
    @(negedge clk) rst = 0;
    // good comparator, combinational
    run(0, -1, cyc);
    chk("g0_cycles", cyc, 16);
    chk("g0_len", seq.size(), 16);
    for (int i = 0; i < 16 && i < seq.size(); i++) chk("g0_vec", 32'(seq[i][1:0]), 32'(vec_at(i)));
    check_result(0, 0);
    // inverted comparator, 4 vectors
    run(1, -1, cyc);
    chk("g1_cycles", cyc, 4);
    check_result(1, 1);
    // latency-matched pipeline
    run(2, -1, cyc);
    chk("g2_cycles", cyc, 48);
    check_result(2, 0);
    // latency-mismatched pipeline must report errors
    run(3, -1, cyc);
    chk("g3_cycles", cyc, 32);
    chk("g3_errs", 32'(errc[3] > 0), 1);
    chk("g3_pass", 32'(pass[3]), 0);
    // a>b reference
    run(4, -1, cyc);
    for (int i = 0; i < 4 && i < seq.size(); i++) chk("g4_out", 32'(seq[i][2]), 32'(vec_at(i) == 2));
    check_result(4, 0);
    fm[4] = 2;
    run(4, -1, cyc);
    check_result(4, 2);
    // saturation
    run(5, -1, cyc);
    chk("g5_cycles", cyc, 300);
    exp_run(300, 0, 1, e, f);
    chk("g5_sat", 32'(e), 255);
    check_result(5, 1);
    // restart attempt while busy is ignored
    run(0, 3, cyc);
    chk("repulse_cycles", cyc, 16);
    check_result(0, 0);
    // reset mid-run
    saved.delete();
    @(negedge clk) start[0] = 1;
    @(posedge clk) #1 start[0] = 0;
    saved.push_back({dut_out[0], dut_a[0], dut_b[0]});
    for (int i = 1; i < 5; i++) begin
      @(posedge clk) #1;
      saved.push_back({dut_out[0], dut_a[0], dut_b[0]});
    end
    @(negedge clk) rst = 1;
    @(posedge clk) #1;
    chk("mid_busy", 32'(busy[0]), 0);
    chk("mid_done", 32'(done[0]), 0);
    chk("mid_ab", 32'({dut_a[0], dut_b[0]}), 0);
    chk("mid_err", 32'(errc[0]), 0);
    chk("mid_first", 32'(first[0]), 32'hFF);
    @(negedge clk) rst = 0;
    saw_done = 0;
    repeat (20) begin
      @(posedge clk) #1;
      saw_done |= done[0];
    end
    chk("mid_no_done", 32'(saw_done), 0);
    run(0, -1, cyc);
    chk("rerun_cycles", cyc, 16);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("rerun_vec", 32'(seq[i][1:0]), 32'(saved[i][1:0]));
    check_result(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
